// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers: 1-cycle MULT, 32-cycle restoring DIV.
// Latency: MULT result in HI/LO two cycles after start; DIV thirty-three cycles after start.
// Backpressure: stall holds EX while busy; the result waits in DONE until ex_allowout or flush.
//
// Ports:
//   clk, rst                 - clock (rising edge), asynchronous active-high reset
//   ex_valid, mult, div      - EX-stage instruction valid and its MULT(U)/DIV(U) decode
//   mdsign                   - 1 signed, 0 unsigned operation
//   hilowen                  - MTHI (bit1) / MTLO (bit0) write enables, ignored for mult/div
//   rega, regb               - GPR[rs], GPR[rt] operands
//   flush, ex_allowout       - kill of the EX instruction / downstream accepts EX
//   stall                    - hold EX while an operation is in progress
//   hi_o, lo_o               - HI and LO registers, driven straight from flops
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    input  logic        flush,
    input  logic        ex_allowout,
    output logic        stall,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // The state register also records the latched op type (S_MUL vs S_DIV).
    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sign;
    logic [5:0]  r_cnt;
    logic [31:0] r_quo;     // dividend shifts out the top, quotient bits shift in the bottom
    logic [31:0] r_rem;     // partial remainder
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_start;
    logic        w_mtx;
    logic [31:0] w_absa_in;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [31:0] w_absb;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_qfix;
    logic [31:0] w_rfix;

    assign w_idle  = (r_state == S_IDLE);
    assign w_start = ex_valid & (mult | div) & ~flush & w_idle;
    assign w_mtx   = ex_valid & ~flush & ~mult & ~div & w_idle;
    assign stall   = ~flush & (w_start | (r_state == S_MUL) | (r_state == S_DIV));

    assign w_absa_in = (mdsign & rega[31]) ? (~rega + 32'd1) : rega;

    // Sign- or zero-extend to 64 bits so one unsigned multiply covers both flavours.
    assign w_ma   = {{32{r_sign & r_a[31]}}, r_a};
    assign w_mb   = {{32{r_sign & r_b[31]}}, r_b};
    assign w_prod = w_ma * w_mb;

    // One restoring-division step. A zero divisor always "fits", giving Q=all ones, R=dividend.
    assign w_absb    = (r_sign & r_b[31]) ? (~r_b + 32'd1) : r_b;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, w_absb});
    // The true difference is below the divisor, so 32-bit wraparound is exact.
    assign w_rem_nxt = w_ge ? (w_shift[31:0] - w_absb) : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    // Sign fix: quotient takes the XOR of operand signs, remainder follows the dividend.
    assign w_qfix = (r_sign & (r_a[31] ^ r_b[31])) ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
    assign w_rfix = (r_sign & r_a[31])             ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_sign  <= 1'b0;
            r_cnt   <= 6'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (flush) begin
            // Kill whatever is in flight; HI/LO keep their old contents.
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a     <= rega;
                        r_b     <= regb;
                        r_sign  <= mdsign;
                        r_cnt   <= 6'd0;
                        r_rem   <= 32'd0;
                        r_quo   <= w_absa_in;
                        r_state <= mult ? S_MUL : S_DIV;
                    end else if (w_mtx) begin
                        if (hilowen[1]) r_hi <= rega;
                        if (hilowen[0]) r_lo <= rega;
                    end
                end
                S_MUL: begin
                    r_hi    <= w_prod[63:32];
                    r_lo    <= w_prod[31:0];
                    r_state <= S_DONE;
                end
                S_DIV: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_cnt == 6'd31) begin
                        r_hi    <= w_rfix;
                        r_lo    <= w_qfix;
                        r_cnt   <= 6'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    if (ex_allowout) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        mult;
    logic        div;
    logic        mdsign;
    logic [1:0]  hilowen;
    logic [31:0] rega;
    logic [31:0] regb;
    logic        flush;
    logic        ex_allowout;
    logic        stall;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    mdu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .mult        (mult),
        .div         (div),
        .mdsign      (mdsign),
        .hilowen     (hilowen),
        .rega        (rega),
        .regb        (regb),
        .flush       (flush),
        .ex_allowout (ex_allowout),
        .stall       (stall),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        mult        = 1'b0;
        div         = 1'b0;
        mdsign      = 1'b0;
        hilowen     = 2'b00;
        flush       = 1'b0;
        ex_allowout = 1'b0;
    endtask

    // Issue one MULT/DIV, count stall cycles (bounded), check HI/LO, check DONE holds.
    task automatic run_op(input string tag, input logic m, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        ex_valid = 1'b1; mult = m; div = d; mdsign = s; rega = a; regb = b;
        ex_allowout = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            // Operands are latched at start; later changes must not matter.
            if (n == 1) begin rega = 32'h5A5A_1234; regb = 32'h0000_0009; mdsign = ~s; end
            #1;
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        // Still DONE with the same instruction presented: no restart, no stall.
        @(negedge clk); #1;
        chk({tag, "_done_hold"}, {63'd0, stall}, 64'd0);
        ex_valid = 1'b0; mult = 1'b0; div = 1'b0; ex_allowout = 1'b1;
        @(negedge clk);
        ex_allowout = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rega = 32'd0;
        regb = 32'd0;
        rst  = 1'b1;
        #1;
        chk("reset_hi", {32'd0, hi_o}, 64'd0);
        chk("reset_lo", {32'd0, lo_o}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_signed", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("divu_100_7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div_m7_2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("div_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("divu_5_0", 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);

        // MTHI + MTLO of 0x12345678, then flush a DIV at iteration 10.
        @(negedge clk);
        ex_valid = 1'b1; hilowen = 2'b11; rega = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mt_both_hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
        chk("mt_both_lo", {32'd0, lo_o}, {32'd0, 32'h1234_5678});
        @(negedge clk);
        ex_valid = 1'b1; div = 1'b1; mdsign = 1'b0; rega = 32'd1000; regb = 32'd3;
        #1;
        chk("flushdiv_start_stall", {63'd0, stall}, 64'd1);
        for (int i = 0; i <= 10; i++) @(negedge clk);
        #1;
        chk("flushdiv_iter10_stall", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall_same_cycle", {63'd0, stall}, 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_idle_next", {63'd0, stall}, 64'd0);
        chk("flush_hi_kept", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
        chk("flush_lo_kept", {32'd0, lo_o}, {32'd0, 32'h1234_5678});
        // Well past where the division would have finished: still nothing written.
        for (int i = 0; i < 30; i++) @(negedge clk);
        #1;
        chk("flush_hi_late", {32'd0, hi_o}, {32'd0, 32'h1234_5678});

        // MTHI only, then read next cycle; LO must be untouched.
        @(negedge clk);
        ex_valid = 1'b1; hilowen = 2'b10; rega = 32'hCAFE_BABE;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mthi_hi", {32'd0, hi_o}, {32'd0, 32'hCAFE_BABE});
        chk("mthi_lo_kept", {32'd0, lo_o}, {32'd0, 32'h1234_5678});

        // MTLO presented together with flush is dropped.
        @(negedge clk);
        ex_valid = 1'b1; hilowen = 2'b01; rega = 32'hDEAD_0001; flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mtlo_flushed", {32'd0, lo_o}, {32'd0, 32'h1234_5678});

        // Reset pulse in the middle of a MULT.
        @(negedge clk);
        ex_valid = 1'b1; mult = 1'b1; mdsign = 1'b0; rega = 32'd6; regb = 32'd7;
        @(negedge clk);
        #1;
        chk("rstmul_busy", {63'd0, stall}, 64'd1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rstmul_hi", {32'd0, hi_o}, 64'd0);
        chk("rstmul_lo", {32'd0, lo_o}, 64'd0);
        chk("rstmul_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmul_after_lo", {32'd0, lo_o}, 64'd0);

        // Unit still works after the reset.
        run_op("mult_after_rst", 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 2, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: ex_valid  in  1  EX-stage instruction valid.
REQ-004 SHALL have port: mult  in  1  EX instruction is MULT/MULTU.
REQ-005 SHALL have port: div  in  1  EX instruction is DIV/DIVU.
REQ-006 SHALL have port: mdsign  in  1  1 signed, 0 unsigned; valid with mult/div.
REQ-007 SHALL have port: hilowen  in  2  bit0 write LO, bit1 write HI (MTLO/MTHI); ignored when mult|div.
REQ-008 SHALL have port: rega  in  32  GPR[rs]; dividend/multiplicand, MTHI/MTLO source.
REQ-009 SHALL have port: regb  in  32  GPR[rt]; divisor/multiplier.
REQ-010 SHALL have port: flush  in  1  exception/ERET kill of EX instruction.
REQ-011 SHALL have port: ex_allowout  in  1  downstream accepts the EX instruction this cycle.
REQ-012 SHALL have port: stall  out  1  hold EX; operation in progress.
REQ-013 SHALL have port: hi_o  out  32  current HI register.
REQ-014 SHALL have port: lo_o  out  32  current LO register.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-016 SHALL define start = ex_valid & (mult|div) & ~flush & state==IDLE; on start, latch rega, regb, mdsign, op type.
REQ-017 SHALL on start go IDLE->MUL (mult) or IDLE->DIV (div).
REQ-018 SHALL compute the 64-bit product in MUL (signed or unsigned per mdsign), one cycle, then ->DONE.
REQ-019 SHALL in DIV perform 32-iteration restoring division on absolute values, 6-bit counter 0..31, one quotient bit per cycle; ->DONE after iteration 31.
REQ-020 SHALL for signed div negate quotient when rega[31]^regb[31], negate remainder when rega[31].
REQ-021 SHALL treat divide-by-zero as normal: unsigned Q=0xFFFFFFFF, R=dividend; signed = same algorithm plus REQ-020 sign fix; no exception.
REQ-022 SHALL give 0x80000000 / 0xFFFFFFFF (signed) Q=0x80000000, R=0.
REQ-023 SHALL write HI=product[63:32]/remainder, LO=product[31:0]/quotient on the edge entering DONE.
REQ-024 SHALL drive stall = ~flush & (start | state==MUL | state==DIV); stall=0 in DONE and IDLE.
REQ-025 SHALL latency: mult start cycle T, DONE at T+2; div start T, DONE at T+33.
REQ-026 SHALL hold DONE until ex_allowout=1 or flush=1, then ->IDLE; no new start while in DONE.
REQ-027 SHALL on ex_valid & ~flush & ~mult & ~div & state==IDLE write rega to HI if hilowen[1], LO if hilowen[0], at that edge.
REQ-028 SHALL on flush in any state go ->IDLE at next edge, discard in-flight result, leave HI/LO unchanged that edge.
REQ-029 SHALL drive hi_o/lo_o directly from registers (no combinational bypass).
REQ-030 SHALL ignore input changes during MUL/DIV (latched operands only).

Reset
REQ-031 SHALL on rst=1 immediately: state=IDLE, counter=0, HI=0, LO=0, stall=0, latched operands=0.
REQ-032 SHALL on rst asserted mid-MUL/DIV abort with no HI/LO write.

Verification
REQ-033 SHALL test MULT rega=0xFFFFFFFE, regb=3, mdsign=1 -> stall=1 for 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 SHALL test DIVU 100/7 -> stall=1 for 33 cycles, then HI=2, LO=14.
REQ-035 SHALL test DIV -7/2 signed -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL test DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, no exception.
REQ-037 SHALL test flush at DIV iteration 10 with HI=LO=0x12345678 -> stall drops same cycle, IDLE next cycle, HI/LO remain 0x12345678.
REQ-038 SHALL test MTHI 0xCAFEBABE then MFHI next cycle -> hi_o=0xCAFEBABE; rst pulse mid-MULT -> HI=LO=0, stall=0.
